// File: rtl/adc_sar_matrix_ctrl.sv
// SAR sequencer and unary-matrix + binary-LSB capacitor-array driver.
// Runs sample phase, RES-step binary search, and returns the code over valid/ready.
module adc_sar_matrix_ctrl #(
    parameter int unsigned RES           = 12,
    parameter int unsigned ROWS          = 16,
    parameter int unsigned COLS          = 32,
    parameter int unsigned LSB_BITS      = RES - $clog2(ROWS * COLS),
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                comp_in,
    output logic                busy,
    output logic [RES-1:0]      data,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                sample,
    output logic                sample_n,
    output logic                sw,
    output logic                sw_n,
    output logic [ROWS-1:0]     row_n,
    output logic [ROWS-1:0]     rowon_n,
    output logic [ROWS-1:0]     rowoff_n,
    output logic [COLS-1:0]     col,
    output logic [COLS-1:0]     col_n,
    output logic [LSB_BITS-1:0] en_bit_n,
    output logic                en_C0_n
);

    localparam int unsigned M_BITS   = $clog2(ROWS * COLS);
    localparam int unsigned ROW_BITS = $clog2(ROWS);
    localparam int unsigned COL_BITS = $clog2(COLS);
    localparam int unsigned BIT_W    = (RES > 1) ? $clog2(RES) : 1;
    localparam int unsigned CNT_MAX  = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ?
                                       SAMPLE_CYCLES : SETTLE_CYCLES + 1;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [RES-1:0]      trial_q, trial_d;
    logic [RES-1:0]      result_q, result_d;
    logic [RES-1:0]      data_q, data_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic                sample_q, sample_d;
    logic                sample_n_q, sample_n_d;
    logic                sw_q, sw_d;
    logic                sw_n_q, sw_n_d;
    logic                en_c0_n_q, en_c0_n_d;
    logic [ROWS-1:0]     row_n_q, row_n_d;
    logic [ROWS-1:0]     rowon_n_q, rowon_n_d;
    logic [ROWS-1:0]     rowoff_n_q, rowoff_n_d;
    logic [COLS-1:0]     col_q, col_d;
    logic [COLS-1:0]     col_n_q, col_n_d;
    logic [LSB_BITS-1:0] en_bit_n_q, en_bit_n_d;

    logic [RES-1:0]      bit_mask;
    logic [RES-1:0]      code_d;
    logic [M_BITS-1:0]   unary_m;
    logic [ROW_BITS-1:0] full_rows;
    logic [COL_BITS-1:0] part_cols;

    assign bit_mask = RES'(1) << bit_q;

    // Sequencer: state, counters and the successive-approximation registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        trial_d      = trial_q;
        result_d     = result_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_d  = ST_CONV;
                    cnt_d    = '0;
                    bit_d    = BIT_W'(RES - 1);
                    trial_d  = RES'(1) << (RES - 1);
                    result_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                    cnt_d    = '0;
                    result_d = comp_in ? (result_q | bit_mask) : result_q;
                    if (bit_q == '0) begin
                        state_d = ST_DONE;
                        trial_d = '0;
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        trial_d = result_d | (bit_mask >> 1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // valid rises one clock after entry so the final decision is latched first
                if (data_valid_q && data_ready) begin
                    state_d      = ST_IDLE;
                    data_valid_d = 1'b0;
                end else if (!data_valid_q) begin
                    data_valid_d = 1'b1;
                    data_d       = result_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE) && !data_valid_d;
        sample_d   = (state_d == ST_SAMPLE);
        sample_n_d = !sample_d;
        sw_d       = (state_d == ST_SAMPLE);
        sw_n_d     = !sw_d;
        en_c0_n_d  = !((state_d == ST_SAMPLE) || (state_d == ST_CONV));
        code_d     = (state_d == ST_CONV) ? trial_d : '0;
    end

    // Array encoder: code 0 reproduces the idle pattern (all rows off, LSBs off)
    always_comb begin
        unary_m    = code_d[RES-1:LSB_BITS];
        full_rows  = unary_m[M_BITS-1:COL_BITS];
        part_cols  = unary_m[COL_BITS-1:0];
        row_n_d    = '1;
        rowon_n_d  = '1;
        rowoff_n_d = '1;
        col_d      = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (ROW_BITS'(r) < full_rows) begin
                rowon_n_d[r] = 1'b0;
            end else if ((ROW_BITS'(r) == full_rows) && (part_cols != '0)) begin
                row_n_d[r] = 1'b0;
            end else begin
                rowoff_n_d[r] = 1'b0;
            end
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            col_d[c] = (COL_BITS'(c) < part_cols);
        end
        col_n_d    = ~col_d;
        en_bit_n_d = ~code_d[LSB_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            trial_q      <= '0;
            result_q     <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            sample_q     <= 1'b0;
            sample_n_q   <= 1'b1;
            sw_q         <= 1'b0;
            sw_n_q       <= 1'b1;
            en_c0_n_q    <= 1'b1;
            row_n_q      <= '1;
            rowon_n_q    <= '1;
            rowoff_n_q   <= '0;
            col_q        <= '0;
            col_n_q      <= '1;
            en_bit_n_q   <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            trial_q      <= trial_d;
            result_q     <= result_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            sample_q     <= sample_d;
            sample_n_q   <= sample_n_d;
            sw_q         <= sw_d;
            sw_n_q       <= sw_n_d;
            en_c0_n_q    <= en_c0_n_d;
            row_n_q      <= row_n_d;
            rowon_n_q    <= rowon_n_d;
            rowoff_n_q   <= rowoff_n_d;
            col_q        <= col_d;
            col_n_q      <= col_n_d;
            en_bit_n_q   <= en_bit_n_d;
        end
    end

    assign busy       = busy_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign sample     = sample_q;
    assign sample_n   = sample_n_q;
    assign sw         = sw_q;
    assign sw_n       = sw_n_q;
    assign row_n      = row_n_q;
    assign rowon_n    = rowon_n_q;
    assign rowoff_n   = rowoff_n_q;
    assign col        = col_q;
    assign col_n      = col_n_q;
    assign en_bit_n   = en_bit_n_q;
    assign en_C0_n    = en_c0_n_q;

endmodule

// File: tb/tb_adc_sar_matrix_ctrl.sv
// Bench for adc_sar_matrix_ctrl: comparator model, array-encoding reference and result scoreboard.
module tb_adc_sar_matrix_ctrl;

    localparam int unsigned RES      = 12;
    localparam int unsigned ROWS     = 16;
    localparam int unsigned COLS     = 32;
    localparam int unsigned LSB      = 3;
    localparam int unsigned SAMPLE_C = 4;
    localparam int unsigned SETTLE_C = 1;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                comp_in;
    logic                busy;
    logic [RES-1:0]      data;
    logic                data_valid;
    logic                data_ready;
    logic                sample, sample_n, sw, sw_n;
    logic [ROWS-1:0]     row_n, rowon_n, rowoff_n;
    logic [COLS-1:0]     col, col_n;
    logic [LSB-1:0]      en_bit_n;
    logic                en_C0_n;

    int checks = 0;
    int errors = 0;
    logic [RES-1:0] exp_q[$];

    adc_sar_matrix_ctrl #(
        .RES(RES), .ROWS(ROWS), .COLS(COLS), .LSB_BITS(LSB),
        .SAMPLE_CYCLES(SAMPLE_C), .SETTLE_CYCLES(SETTLE_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .comp_in(comp_in),
        .busy(busy), .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .sample(sample), .sample_n(sample_n), .sw(sw), .sw_n(sw_n),
        .row_n(row_n), .rowon_n(rowon_n), .rowoff_n(rowoff_n),
        .col(col), .col_n(col_n), .en_bit_n(en_bit_n), .en_C0_n(en_C0_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference array pattern for a trial code, derived from unit counts
    task automatic check_array(input string tag, input logic [RES-1:0] t);
        int m, l, nfull, npart;
        logic [ROWS-1:0] e_rn, e_ron, e_roff;
        logic [COLS-1:0] e_col;
        logic [LSB-1:0]  e_eb;
        m     = int'(t) / (1 << LSB);
        l     = int'(t) % (1 << LSB);
        nfull = m / COLS;
        npart = m % COLS;
        for (int r = 0; r < ROWS; r++) begin
            e_rn[r]   = !(r == nfull && npart != 0);
            e_ron[r]  = !(r < nfull);
            e_roff[r] = (r < nfull) || (r == nfull && npart != 0);
        end
        for (int c = 0; c < COLS; c++) e_col[c] = (c < npart);
        e_eb = ~LSB'(l);
        chk({tag, " row_n"}, row_n, e_rn);
        chk({tag, " rowon_n"}, rowon_n, e_ron);
        chk({tag, " rowoff_n"}, rowoff_n, e_roff);
        chk({tag, " col"}, col, e_col);
        chk({tag, " en_bit_n"}, en_bit_n, e_eb);
    endtask

    task automatic chk_reset(input string tag);
        logic [ROWS-1:0] r1;
        logic [COLS-1:0] c1;
        logic [LSB-1:0]  b1;
        r1 = '1; c1 = '1; b1 = '1;
        chk({tag, " busy"}, busy, 0);
        chk({tag, " data"}, data, 0);
        chk({tag, " data_valid"}, data_valid, 0);
        chk({tag, " sample"}, sample, 0);
        chk({tag, " sample_n"}, sample_n, 1);
        chk({tag, " sw"}, sw, 0);
        chk({tag, " sw_n"}, sw_n, 1);
        chk({tag, " row_n"}, row_n, r1);
        chk({tag, " rowon_n"}, rowon_n, r1);
        chk({tag, " rowoff_n"}, rowoff_n, 0);
        chk({tag, " col"}, col, 0);
        chk({tag, " col_n"}, col_n, c1);
        chk({tag, " en_bit_n"}, en_bit_n, b1);
        chk({tag, " en_C0_n"}, en_C0_n, 1);
    endtask

    // mode 0: comparator against vin, 1: comparator stuck high, 2: random decisions
    task automatic run_conv(input logic [RES-1:0] vin, input int mode, input int abort_bit);
        logic [RES-1:0] dec_bits, kept, trial, expv, onek;
        logic           dec;
        logic           any_valid;
        dec_bits = RES'($urandom);
        case (mode)
            0:       expv = vin;
            1:       expv = '1;
            default: expv = dec_bits;
        endcase
        if (abort_bit < 0) exp_q.push_back(expv);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < SAMPLE_C; i++) begin
            @(negedge clk);
            chk("sample busy", busy, 1);
            chk("sample phase", sample, 1);
            chk("sample sw", sw, 1);
            chk("sample en_C0_n", en_C0_n, 0);
            if (i == 0) check_array("sample", '0);
            @(posedge clk); #1;
        end
        kept = '0;
        for (int k = RES - 1; k >= 0; k--) begin
            onek  = RES'(1) << k;
            trial = kept | onek;
            case (mode)
                0:       dec = (trial <= vin);
                1:       dec = 1'b1;
                default: dec = dec_bits[k];
            endcase
            comp_in = dec;
            for (int s = 0; s <= SETTLE_C; s++) begin
                @(negedge clk);
                chk("conv sample", sample, 0);
                chk("conv en_C0_n", en_C0_n, 0);
                check_array("conv", trial);
                if (trial == 12'h800) begin
                    chk("t800 rowon_n", rowon_n, 16'hFF00);
                    chk("t800 rowoff_n", rowoff_n, 16'h00FF);
                    chk("t800 en_bit_n", en_bit_n, 3'b111);
                end
                if (trial == 12'h2B5) begin
                    chk("t2B5 col", col, 32'h003FFFFF);
                    chk("t2B5 row_n", row_n, 16'hFFFB);
                    chk("t2B5 rowon_n", rowon_n, 16'hFFFC);
                    chk("t2B5 rowoff_n", rowoff_n, 16'h0007);
                    chk("t2B5 en_bit_n", en_bit_n, 3'b010);
                end
                if (k == abort_bit && s == 0) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset("abort");
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    comp_in = 1'b0;
                    any_valid = 1'b0;
                    for (int j = 0; j < 40; j++) begin
                        @(negedge clk);
                        any_valid = any_valid | data_valid | busy;
                    end
                    chk("abort no valid", any_valid, 0);
                    @(posedge clk); #1;
                    return;
                end
                @(posedge clk); #1;
            end
            if (dec) kept = trial;
        end
        @(negedge clk);
        chk("pre-done valid", data_valid, 0);
        chk("pre-done busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency valid", data_valid, 1);
        chk("done busy", busy, 0);
        check_array("done", '0);
        @(posedge clk); #1;
    endtask

    // Result scoreboard: compares on every accepted transfer
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected result", 1, 0);
            end else begin
                chk("result data", data, exp_q.pop_front());
            end
        end
    end

    // Complementary pairs and one-low-per-row hold every cycle
    always @(negedge clk) begin
        logic ok;
        int   zeros;
        ok = 1'b1;
        if (sample_n !== ~sample) ok = 1'b0;
        if (sw_n !== ~sw) ok = 1'b0;
        if (col_n !== ~col) ok = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            zeros = 0;
            if (row_n[r] === 1'b0) zeros++;
            if (rowon_n[r] === 1'b0) zeros++;
            if (rowoff_n[r] === 1'b0) zeros++;
            if (zeros != 1) ok = 1'b0;
        end
        chk("invariants", ok, 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; comp_in = 1'b0; data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset("in reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("after reset");
        chk("reset rowoff_n", rowoff_n, 16'h0000);
        chk("reset row_n", row_n, 16'hFFFF);
        chk("reset en_bit_n", en_bit_n, 3'b111);
        @(posedge clk); #1;

        run_conv('0, 1, -1);
        run_conv(12'hA5C, 0, -1);
        run_conv(12'h2B5, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_conv(RES'($urandom), (i % 2 == 0) ? 0 : 2, -1);
        end
        run_conv(12'h000, 0, -1);
        run_conv(12'hFFF, 0, -1);

        // Consumer stalls; a start during DONE must be ignored
        data_ready = 1'b0;
        run_conv(12'h123, 0, -1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            chk("hold valid", data_valid, 1);
            chk("hold busy", busy, 0);
            chk("hold sample", sample, 0);
            chk("hold data", data, 12'h123);
            @(posedge clk); #1;
        end
        start = 1'b0;
        data_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release valid", data_valid, 0);
        chk("release busy", busy, 0);
        @(posedge clk); #1;
        run_conv(RES'($urandom), 0, -1);

        run_conv(12'h5A5, 0, 5);
        run_conv(12'h3C7, 0, -1);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
